// File: rtl/cache_fill_ctrl.sv
// Lookup and miss-fill controller for a 2-way, 64-set cache: hit detection, LRU strobe,
// victim choice, 8-word block fetch from fixed-latency memory and metadata write-back.
module cache_fill_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        access,
  input  logic        is_write,
  input  logic [15:0] addr,
  input  logic [7:0]  meta_out1,
  input  logic [7:0]  meta_out2,
  input  logic        mem_data_valid,
  output logic [63:0] meta_block_en,
  output logic [7:0]  meta_din,
  output logic        meta_hit,
  output logic        meta_write1,
  output logic        meta_write2,
  output logic        data_way,
  output logic [7:0]  data_word_en,
  output logic        data_write,
  output logic        mem_en,
  output logic [15:0] mem_addr,
  output logic        stall,
  output logic        fill_done,
  output logic [1:0]  dbg_state
);

  localparam logic [2:0] LAST_WORD = 3'd7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    META = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t      r_state, w_next;
  logic [5:0]  r_tag;
  logic [5:0]  r_set;
  logic        r_victim;
  logic [2:0]  r_iss_cnt;
  logic        r_iss_done;
  logic [2:0]  r_rcv_cnt;

  logic        w_hit1, w_hit2, w_hit;
  logic        w_victim;
  logic        w_lookup;
  logic        w_miss;
  logic        w_issue;
  logic        w_recv;
  logic        w_unused;

  // Stores take the same write-allocate fill path; the byte bit never matters here.
  assign w_unused = ^{is_write, addr[3:0]};

  assign w_hit1 = meta_out1[0] & (meta_out1[7:2] == addr[15:10]);
  assign w_hit2 = meta_out2[0] & (meta_out2[7:2] == addr[15:10]);
  assign w_hit  = w_hit1 | w_hit2;

  always_comb begin
    w_victim = 1'b0;
    if (!meta_out1[0])                      w_victim = 1'b0;
    else if (!meta_out2[0])                 w_victim = 1'b1;
    else if (meta_out2[1] && !meta_out1[1]) w_victim = 1'b1;
    else                                    w_victim = 1'b0;
  end

  // Lookup is gated by rst so the LRU strobe stays quiet while reset is held.
  assign w_lookup = access & rst & (r_state == IDLE);
  assign w_miss   = w_lookup & ~w_hit;
  assign w_issue  = (r_state == FILL) & ~r_iss_done;
  assign w_recv   = (r_state == FILL) & mem_data_valid;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next        = r_state;
    meta_block_en = 64'd1 << r_set;
    meta_din      = {r_tag, r_victim, 1'b0};
    meta_hit      = 1'b0;
    meta_write1   = 1'b0;
    meta_write2   = 1'b0;
    data_way      = r_victim;
    data_word_en  = 8'd0;
    data_write    = 1'b0;
    mem_en        = 1'b0;
    mem_addr      = {r_tag, r_set, r_iss_cnt, 1'b0};
    stall         = 1'b0;
    fill_done     = 1'b0;
    case (r_state)
      IDLE: begin
        meta_block_en = 64'd1 << addr[9:4];
        meta_din      = {addr[15:10], ~w_hit1 & w_hit2, 1'b0};
        meta_hit      = w_lookup & w_hit;
        stall         = access & ~w_hit;
        if (w_miss) w_next = FILL;
      end
      FILL: begin
        stall  = 1'b1;
        mem_en = w_issue;
        if (w_recv) begin
          data_write   = 1'b1;
          data_word_en = 8'd1 << r_rcv_cnt;
          if (r_rcv_cnt == LAST_WORD) w_next = META;
        end
      end
      META: begin
        stall       = 1'b1;
        meta_write1 = ~r_victim;
        meta_write2 = r_victim;
        w_next      = DONE;
      end
      DONE: begin
        fill_done = 1'b1;
        w_next    = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_tag      <= 6'd0;
      r_set      <= 6'd0;
      r_victim   <= 1'b0;
      r_iss_cnt  <= 3'd0;
      r_iss_done <= 1'b0;
      r_rcv_cnt  <= 3'd0;
    end else begin
      if (w_miss) begin
        r_tag      <= addr[15:10];
        r_set      <= addr[9:4];
        r_victim   <= w_victim;
        r_iss_cnt  <= 3'd0;
        r_iss_done <= 1'b0;
        r_rcv_cnt  <= 3'd0;
      end else begin
        if (w_issue) begin
          r_iss_cnt <= r_iss_cnt + 3'd1;
          if (r_iss_cnt == LAST_WORD) r_iss_done <= 1'b1;
        end
        if (w_recv) r_rcv_cnt <= r_rcv_cnt + 3'd1;
      end
    end
  end

  assign dbg_state = r_state;

endmodule

// File: tb/tb_cache_fill_ctrl.sv
// Directed bench for cache_fill_ctrl: hits, full fills with victim choice, gapped returns,
// address churn during a fill and an asynchronous reset in the middle of a fill.
module tb_cache_fill_ctrl;

  logic        clk;
  logic        rst;
  logic        access;
  logic        is_write;
  logic [15:0] addr;
  logic [7:0]  meta_out1;
  logic [7:0]  meta_out2;
  logic        mem_data_valid;
  logic [63:0] meta_block_en;
  logic [7:0]  meta_din;
  logic        meta_hit;
  logic        meta_write1;
  logic        meta_write2;
  logic        data_way;
  logic [7:0]  data_word_en;
  logic        data_write;
  logic        mem_en;
  logic [15:0] mem_addr;
  logic        stall;
  logic        fill_done;
  logic [1:0]  dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  cache_fill_ctrl dut (
    .clk(clk), .rst(rst), .access(access), .is_write(is_write), .addr(addr),
    .meta_out1(meta_out1), .meta_out2(meta_out2), .mem_data_valid(mem_data_valid),
    .meta_block_en(meta_block_en), .meta_din(meta_din), .meta_hit(meta_hit),
    .meta_write1(meta_write1), .meta_write2(meta_write2), .data_way(data_way),
    .data_word_en(data_word_en), .data_write(data_write), .mem_en(mem_en),
    .mem_addr(mem_addr), .stall(stall), .fill_done(fill_done), .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One full miss sequence. Cycle 0 is the miss-detect cycle; mask bit c drives
  // mem_data_valid in cycle c; meta_c is the cycle where META is expected.
  task automatic run_fill(input logic [15:0] a, input logic [7:0] m1, input logic [7:0] m2,
                          input logic [31:0] mask, input logic vict, input int meta_c,
                          input logic toggle, input string tag);
    int          rcv;
    logic [1:0]  exp_st;
    logic        exp_fill, exp_en, exp_dw;
    logic [15:0] exp_ma;
    logic [2:0]  w;
    rcv = 0;
    for (int c = 0; c <= meta_c + 1; c++) begin
      @(negedge clk);
      if (c == 0 || !toggle) begin
        access = 1'b1; addr = a; meta_out1 = m1; meta_out2 = m2;
      end else begin
        access    = 1'($urandom_range(0, 1));
        addr      = 16'($urandom_range(0, 65535));
        meta_out1 = 8'($urandom_range(0, 255));
        meta_out2 = 8'($urandom_range(0, 255));
      end
      mem_data_valid = mask[c];
      #1;
      exp_st   = (c == 0) ? 2'd0 : (c < meta_c) ? 2'd1 : (c == meta_c) ? 2'd2 : 2'd3;
      exp_fill = (c >= 1) && (c < meta_c);
      exp_en   = (c >= 1) && (c <= 8);
      exp_dw   = exp_fill && mask[c];
      n_checks++;
      if (dbg_state !== exp_st) begin
        n_fail++; $display("FAIL %s state c=%0d got=%0d exp=%0d", tag, c, dbg_state, exp_st);
      end
      n_checks++;
      if (stall !== (c <= meta_c)) begin
        n_fail++; $display("FAIL %s stall c=%0d got=%0b exp=%0b", tag, c, stall, c <= meta_c);
      end
      n_checks++;
      if (mem_en !== exp_en) begin
        n_fail++; $display("FAIL %s mem_en c=%0d got=%0b exp=%0b", tag, c, mem_en, exp_en);
      end
      if (exp_en) begin
        w = 3'(c - 1);
        exp_ma = {a[15:4], w, 1'b0};
        n_checks++;
        if (mem_addr !== exp_ma) begin
          n_fail++; $display("FAIL %s mem_addr c=%0d got=%h exp=%h", tag, c, mem_addr, exp_ma);
        end
      end
      if (c >= 1) begin
        n_checks++;
        if (meta_block_en !== (64'd1 << a[9:4])) begin
          n_fail++; $display("FAIL %s block_en c=%0d got=%h exp=%h", tag, c, meta_block_en,
                             64'd1 << a[9:4]);
        end
      end
      n_checks++;
      if (data_write !== exp_dw) begin
        n_fail++; $display("FAIL %s data_write c=%0d got=%0b exp=%0b", tag, c, data_write, exp_dw);
      end
      if (exp_dw) begin
        n_checks++;
        if (data_word_en !== (8'd1 << rcv) || data_way !== vict) begin
          n_fail++; $display("FAIL %s word_en/way c=%0d got=%h/%0b exp=%h/%0b", tag, c,
                             data_word_en, data_way, 8'd1 << rcv, vict);
        end
        rcv++;
      end
      n_checks++;
      if (meta_write1 !== (c == meta_c && !vict) || meta_write2 !== (c == meta_c && vict)) begin
        n_fail++; $display("FAIL %s meta_write c=%0d got=%0b%0b", tag, c, meta_write1, meta_write2);
      end
      if (c == meta_c) begin
        n_checks++;
        if (meta_din !== {a[15:10], vict, 1'b0}) begin
          n_fail++; $display("FAIL %s meta_din got=%h exp=%h", tag, meta_din, {a[15:10], vict, 1'b0});
        end
      end
      n_checks++;
      if (fill_done !== (c == meta_c + 1) || meta_hit !== 1'b0) begin
        n_fail++; $display("FAIL %s done/hit c=%0d got=%0b/%0b", tag, c, fill_done, meta_hit);
      end
    end
    @(negedge clk);
    access = 1'b0; mem_data_valid = 1'b0; addr = a;
  endtask

  task automatic test_reset;
    rst = 1'b0; access = 1'b0; is_write = 1'b0; addr = 16'h0;
    meta_out1 = 8'h0; meta_out2 = 8'h0; mem_data_valid = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    n_checks++;
    if (dbg_state !== 2'd0 || mem_en !== 1'b0 || stall !== 1'b0 || fill_done !== 1'b0 ||
        meta_hit !== 1'b0 || data_write !== 1'b0 || meta_write1 !== 1'b0 || meta_write2 !== 1'b0) begin
      n_fail++; $display("FAIL reset st=%0d en=%0b stall=%0b done=%0b hit=%0b", dbg_state, mem_en,
                         stall, fill_done, meta_hit);
    end
    n_checks++;
    if (mem_addr !== 16'h0) begin
      n_fail++; $display("FAIL reset_mem_addr got=%h exp=0000", mem_addr);
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_hit;
    @(negedge clk);
    access = 1'b1; addr = 16'hA850; meta_out1 = 8'hA9; meta_out2 = 8'h00;
    #1;
    n_checks++;
    if (meta_hit !== 1'b1 || meta_din !== 8'hA8 || stall !== 1'b0) begin
      n_fail++; $display("FAIL hit_way1 got hit=%0b din=%h stall=%0b exp 1/a8/0", meta_hit, meta_din, stall);
    end
    n_checks++;
    if (meta_block_en !== (64'd1 << 5)) begin
      n_fail++; $display("FAIL hit_block_en got=%h exp=%h", meta_block_en, 64'd1 << 5);
    end
    @(negedge clk);
    meta_out1 = 8'h00; meta_out2 = 8'hAB;
    #1;
    n_checks++;
    if (meta_hit !== 1'b1 || meta_din !== 8'hAA || stall !== 1'b0 || dbg_state !== 2'd0) begin
      n_fail++; $display("FAIL hit_way2 got hit=%0b din=%h stall=%0b exp 1/aa/0", meta_hit, meta_din, stall);
    end
    @(negedge clk);
    meta_out1 = 8'hA9; meta_out2 = 8'hAB;
    #1;
    n_checks++;
    if (meta_hit !== 1'b1 || meta_din !== 8'hA8) begin
      n_fail++; $display("FAIL hit_both got hit=%0b din=%h exp 1/a8", meta_hit, meta_din);
    end
    @(negedge clk);
    access = 1'b0;
    #1;
    n_checks++;
    if (meta_hit !== 1'b0 || stall !== 1'b0) begin
      n_fail++; $display("FAIL no_access got hit=%0b stall=%0b exp 0/0", meta_hit, stall);
    end
  endtask

  task automatic test_miss_fill;
    run_fill(16'h1250, 8'h00, 8'h00, 32'h0000_0FF1, 1'b0, 12, 1'b0, "fill_inv");
    @(negedge clk);
    access = 1'b1; addr = 16'h1250; meta_out1 = 8'h10 | 8'h01; meta_out2 = 8'h00;
    #1;
    n_checks++;
    if (meta_hit !== 1'b1 || stall !== 1'b0) begin
      n_fail++; $display("FAIL refetch_hit got hit=%0b stall=%0b exp 1/0", meta_hit, stall);
    end
    @(negedge clk);
    access = 1'b0;
  endtask

  task automatic test_victim_lru;
    run_fill(16'h1250, 8'h45, 8'h8B, 32'h0000_1FF0, 1'b1, 12, 1'b0, "lru_w2");
    run_fill(16'h3C7E, 8'h47, 8'h8B, 32'h0000_0FF0, 1'b0, 12, 1'b0, "lru_both");
    run_fill(16'h3C7E, 8'h45, 8'h00, 32'h0000_0FF0, 1'b1, 12, 1'b0, "w2_inv");
  endtask

  task automatic test_gaps;
    run_fill(16'h0440, 8'h00, 8'h00, 32'h0000_FE50, 1'b0, 15, 1'b0, "gaps");
  endtask

  task automatic test_toggle;
    run_fill(16'hFFF0, 8'h47, 8'h8D, 32'h0000_0FF0, 1'b0, 12, 1'b1, "toggle");
  endtask

  task automatic test_reset_midfill;
    @(negedge clk);
    access = 1'b1; addr = 16'h1250; meta_out1 = 8'h00; meta_out2 = 8'h00;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      mem_data_valid = (c >= 4);
    end
    #1;
    n_checks++;
    if (mem_en !== 1'b1 || data_write !== 1'b1) begin
      n_fail++; $display("FAIL pre_reset got en=%0b dw=%0b exp 1/1", mem_en, data_write);
    end
    rst = 1'b0;
    #1;
    n_checks++;
    if (mem_en !== 1'b0 || data_write !== 1'b0 || meta_write1 !== 1'b0 || meta_write2 !== 1'b0 ||
        fill_done !== 1'b0 || meta_hit !== 1'b0 || dbg_state !== 2'd0) begin
      n_fail++; $display("FAIL mid_reset got en=%0b dw=%0b mw=%0b%0b done=%0b st=%0d", mem_en,
                         data_write, meta_write1, meta_write2, fill_done, dbg_state);
    end
    n_checks++;
    if (stall !== 1'b1) begin
      n_fail++; $display("FAIL mid_reset_stall got=%0b exp=1", stall);
    end
    @(negedge clk);
    access = 1'b0; mem_data_valid = 1'b0;
    rst = 1'b1;
    run_fill(16'h1250, 8'h00, 8'h00, 32'h0000_0FF0, 1'b0, 12, 1'b0, "refill");
  endtask

  initial begin
    test_reset();
    test_hit();
    test_miss_fill();
    test_victim_lru();
    test_gaps();
    test_toggle();
    test_reset_midfill();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout checks=%0d", n_checks);
    $fatal(1, "timeout");
  end

endmodule
